// File: rtl/ram_ctrl_hs.sv
// Single-port data memory behind valid/ready request and response channels.
// One transaction in flight; memory is updated or read on the edge that enters RESP.
module ram_ctrl_hs #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);
    // state  | meaning
    // S_IDLE | ready to accept a request
    // S_WAIT | counting down the access latency
    // S_RESP | response presented until rsp_ready
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BE_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BE_W - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic                  addr_err;
    logic                  accept;
    logic                  commit;

    logic                  c_we;
    logic [IDX_W-1:0]      c_idx;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic [BE_W-1:0]       c_be;
    logic                  c_err;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rdata_next;

    assign off      = req_addr - BASE_ADDR;
    assign idx_full = off >> SHIFT;
    assign addr_err = (req_addr < BASE_ADDR) || ((off & ALIGN_MASK) != '0) || (idx_full >= DEPTH_A);

    assign req_ready = rst_n && (state == S_IDLE);
    assign accept    = req_ready && req_valid;
    assign commit    = (accept && (LATENCY == 1)) || ((state == S_WAIT) && (cnt == 4'd1));

    // With LATENCY=1 the commit happens on the accept edge, so use the live request.
    always_comb begin
        c_we    = we_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        c_err   = err_q;
        if (state == S_IDLE) begin
            c_we    = req_we;
            c_idx   = idx_full[IDX_W-1:0];
            c_wdata = req_wdata;
            c_be    = req_be;
            c_err   = addr_err;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{c_be[i]}};
        end
        old_word   = mem[c_idx];
        merged     = (old_word & ~mask) | (c_wdata & mask);
        rdata_next = c_err ? '0 : (c_we ? merged : old_word);
    end

    // Memory has no reset; a transaction dropped by reset never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            mem[c_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        idx_q   <= idx_full[IDX_W-1:0];
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        err_q   <= addr_err;
                        if (!commit) begin
                            state <= S_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (commit) begin
                state     <= S_RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_next;
                rsp_err   <= c_err;
            end
        end
    end
endmodule

// File: tb/tb_ram_ctrl_hs.sv
// Bench for ram_ctrl_hs: four parameterisations sharing request wires, checked
// against a word-level memory model kept in an associative array.
module tb_ram_ctrl_hs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_err;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        rsp_ready;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [63:0] rdata3;

    int checks   = 0;
    int failures = 0;

    int     P_BW    [4] = '{4, 4, 4, 8};
    int     P_DEPTH [4] = '{1024, 1024, 1024, 16};
    longint P_BASE  [4] = '{0, 0, 'h8000, 0};
    int     P_LAT   [4] = '{1, 4, 2, 3};

    logic [63:0] mdl [longint];

    always #5 clk = ~clk;

    ram_ctrl_hs #(.LATENCY(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_be(req_be[3:0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata0), .rsp_err(rsp_err[0]));

    ram_ctrl_hs #(.LATENCY(4)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_be(req_be[3:0]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata1), .rsp_err(rsp_err[1]));

    ram_ctrl_hs #(.BASE_ADDR(32'h8000), .LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_be(req_be[3:0]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdata2), .rsp_err(rsp_err[2]));

    ram_ctrl_hs #(.DATA_WIDTH(64), .DEPTH(16), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[3]), .rsp_ready(rsp_ready), .rsp_rdata(rdata3), .rsp_err(rsp_err[3]));

    function automatic logic [63:0] get_rdata(input int k);
        case (k)
            0:       return {32'h0, rdata0};
            1:       return {32'h0, rdata1};
            2:       return {32'h0, rdata2};
            default: return rdata3;
        endcase
    endfunction

    // Word-level reference: address arithmetic on plain integers, bytes merged one at a time.
    task automatic model_access(input int k, input logic we, input logic [31:0] addr,
                                input logic [63:0] wd, input logic [7:0] be,
                                output logic [63:0] rd, output logic er, output bit known);
        longint      a;
        longint      off;
        longint      key;
        logic [63:0] w;
        int          nb;
        a     = longint'({32'h0, addr});
        off   = a - P_BASE[k];
        er    = (a < P_BASE[k]) || (off % P_BW[k] != 0) || (off / P_BW[k] >= P_DEPTH[k]);
        rd    = 64'h0;
        known = 1'b1;
        if (er) return;
        key = k * 4096 + off / P_BW[k];
        if (mdl.exists(key)) begin
            w = mdl[key];
        end else begin
            w     = 64'h0;
            known = 1'b0;
        end
        if (we) begin
            nb = 0;
            for (int b = 0; b < P_BW[k]; b++) begin
                if (be[b]) begin
                    w[8*b +: 8] = wd[8*b +: 8];
                    nb++;
                end
            end
            if (nb == P_BW[k]) known = 1'b1;
            if (known) mdl[key] = w;
        end
        rd = w;
    endtask

    task automatic run_txn(input int k, input logic we, input logic [31:0] addr, input logic [63:0] wd,
                           input logic [7:0] be, input int stall, input string name,
                           output logic [63:0] obs);
        logic [63:0] exp_rd;
        logic        exp_err;
        bit          known;
        int          cyc;
        model_access(k, we, addr, wd, be, exp_rd, exp_err, known);
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wd;
        req_be       = be;
        req_valid[k] = 1'b1;
        rsp_ready    = (stall == 0);
        checks++;
        if (req_ready[k] !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready: got %b want 1", name, req_ready[k]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_we       = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = {$urandom, $urandom};
        req_be       = 8'($urandom);
        cyc = 1;
        while (rsp_valid[k] !== 1'b1 && cyc < 40) begin
            checks++;
            if (req_ready[k] !== 1'b0) begin
                failures++;
                $display("FAIL %s wait_ready: got %b want 0 at cycle %0d", name, req_ready[k], cyc);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != P_LAT[k]) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, P_LAT[k]);
        end
        obs = get_rdata(k);
        checks++;
        if (rsp_err[k] !== exp_err) begin
            failures++;
            $display("FAIL %s err: got %b want %b", name, rsp_err[k], exp_err);
        end
        if (known) begin
            checks++;
            if (obs !== exp_rd) begin
                failures++;
                $display("FAIL %s rdata: got %h want %h", name, obs, exp_rd);
            end
        end
        checks++;
        if (req_ready[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s resp_ready: got %b want 0", name, req_ready[k]);
        end
        for (int s = 0; s < stall; s++) begin
            req_valid[k] = 1'b1;
            @(negedge clk);
            checks++;
            if (rsp_valid[k] !== 1'b1 || get_rdata(k) !== obs || rsp_err[k] !== exp_err || req_ready[k] !== 1'b0) begin
                failures++;
                $display("FAIL %s stall%0d: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                         name, s, rsp_valid[k], get_rdata(k), rsp_err[k], req_ready[k], obs, exp_err);
            end
        end
        req_valid[k] = 1'b0;
        rsp_ready    = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || get_rdata(k) !== obs || rsp_err[k] !== exp_err) begin
            failures++;
            $display("FAIL %s after_hs: got v=%b rdy=%b d=%h e=%b want v=0 rdy=1 d=%h e=%b",
                     name, rsp_valid[k], req_ready[k], get_rdata(k), rsp_err[k], obs, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'h0 || rsp_valid !== 4'h0 || rsp_err !== 4'h0) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy=%b v=%b e=%b want 0000", req_ready, rsp_valid, rsp_err);
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0 || rdata2 !== 32'h0 || rdata3 !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h %h %h %h want 0", rdata0, rdata1, rdata2, rdata3);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1111", req_ready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] obs;
        run_txn(0, 1'b1, 32'h10, 64'hDEADBEEF, 8'hF, 0, "wr_full", obs);
        checks++;
        if (obs !== 64'hDEADBEEF) begin failures++; $display("FAIL wr_full_val: got %h want deadbeef", obs); end
        run_txn(0, 1'b0, 32'h10, 64'h0, 8'h0, 0, "rd_full", obs);
        checks++;
        if (obs !== 64'hDEADBEEF) begin failures++; $display("FAIL rd_full_val: got %h want deadbeef", obs); end
        run_txn(0, 1'b1, 32'h10, 64'h11223344, 8'h5, 0, "wr_part", obs);
        checks++;
        if (obs !== 64'hDE22BE44) begin failures++; $display("FAIL wr_part_val: got %h want de22be44", obs); end
        run_txn(0, 1'b0, 32'h10, 64'h0, 8'h0, 1, "rd_part", obs);
        checks++;
        if (obs !== 64'hDE22BE44) begin failures++; $display("FAIL rd_part_val: got %h want de22be44", obs); end
        run_txn(0, 1'b1, 32'h10, 64'h55555555, 8'h0, 0, "wr_be0", obs);
        checks++;
        if (obs !== 64'hDE22BE44) begin failures++; $display("FAIL wr_be0_val: got %h want de22be44", obs); end
    endtask

    task automatic test_latency();
        logic [63:0] obs;
        run_txn(1, 1'b1, 32'h40, 64'hCAFEF00D, 8'hF, 0, "lat4_wr", obs);
        run_txn(1, 1'b0, 32'h40, 64'h0, 8'h0, 3, "lat4_rd_stall", obs);
        checks++;
        if (obs !== 64'hCAFEF00D) begin failures++; $display("FAIL lat4_rd_val: got %h want cafef00d", obs); end
        run_txn(2, 1'b1, 32'h8004, 64'h600DC0DE, 8'hF, 0, "base_wr", obs);
        run_txn(2, 1'b0, 32'h8004, 64'h0, 8'h0, 0, "base_rd", obs);
        checks++;
        if (obs !== 64'h600DC0DE) begin failures++; $display("FAIL base_rd_val: got %h want 600dc0de", obs); end
    endtask

    task automatic test_errors();
        logic [63:0] obs;
        run_txn(0, 1'b0, 32'h12, 64'h0, 8'h0, 0, "rd_misalign", obs);
        checks++;
        if (obs !== 64'h0 || rsp_err[0] !== 1'b1) begin
            failures++; $display("FAIL rd_misalign_val: got d=%h e=%b want d=0 e=1", obs, rsp_err[0]);
        end
        run_txn(0, 1'b1, 32'h0, 64'h0BADF00D, 8'hF, 0, "wr_zero", obs);
        run_txn(0, 1'b1, 32'h1000, 64'hFFFFFFFF, 8'hF, 0, "wr_oor", obs);
        checks++;
        if (rsp_err[0] !== 1'b1) begin failures++; $display("FAIL wr_oor_err: got %b want 1", rsp_err[0]); end
        run_txn(0, 1'b0, 32'h0, 64'h0, 8'h0, 0, "rd_zero", obs);
        checks++;
        if (obs !== 64'h0BADF00D) begin failures++; $display("FAIL rd_zero_val: got %h want 0badf00d", obs); end
        run_txn(2, 1'b0, 32'h7FFC, 64'h0, 8'h0, 0, "rd_below_base", obs);
        checks++;
        if (rsp_err[2] !== 1'b1 || obs !== 64'h0) begin
            failures++; $display("FAIL rd_below_base_err: got e=%b d=%h want e=1 d=0", rsp_err[2], obs);
        end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] obs;
        @(negedge clk);
        req_we       = 1'b1;
        req_addr     = 32'h40;
        req_wdata    = 64'hFFFFFFFF;
        req_be       = 8'hF;
        req_valid[1] = 1'b1;
        rsp_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        checks++;
        if (req_ready[1] !== 1'b0) begin failures++; $display("FAIL midrst_accept: got rdy=%b want 0", req_ready[1]); end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'h0 || req_ready !== 4'h0) begin
            failures++; $display("FAIL midrst_outputs: got v=%b rdy=%b want 0000 0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1, 1'b0, 32'h40, 64'h0, 8'h0, 0, "midrst_rd", obs);
        checks++;
        if (obs !== 64'hCAFEF00D) begin failures++; $display("FAIL midrst_rd_val: got %h want cafef00d", obs); end
    endtask

    task automatic test_wide();
        logic [63:0] obs;
        run_txn(3, 1'b1, 32'h78, 64'h0123456789ABCDEF, 8'hFF, 0, "w64_init", obs);
        run_txn(3, 1'b1, 32'h78, 64'hAABBCCDD_00000000, 8'hF0, 0, "w64_upper", obs);
        run_txn(3, 1'b0, 32'h78, 64'h0, 8'h0, 2, "w64_rd", obs);
        checks++;
        if (obs[63:32] !== 32'hAABBCCDD || obs[31:0] !== 32'h89ABCDEF) begin
            failures++; $display("FAIL w64_rd_val: got %h want aabbccdd89abcdef", obs);
        end
        run_txn(3, 1'b0, 32'h80, 64'h0, 8'h0, 0, "w64_oor", obs);
        checks++;
        if (rsp_err[3] !== 1'b1 || obs !== 64'h0) begin
            failures++; $display("FAIL w64_oor_err: got e=%b d=%h want e=1 d=0", rsp_err[3], obs);
        end
    endtask

    task automatic test_random();
        logic [63:0] obs;
        int          ks [3] = '{0, 1, 3};
        int          k;
        int          idx;
        int          mode;
        longint      a;
        logic [7:0]  bmask;
        for (int j = 0; j < 3; j++) begin
            k     = ks[j];
            bmask = (P_BW[k] == 8) ? 8'hFF : 8'h0F;
            for (int p = 0; p <= 8; p++) begin
                idx = (p == 8) ? P_DEPTH[k] - 1 : p;
                a   = P_BASE[k] + longint'(idx) * P_BW[k];
                run_txn(k, 1'b1, 32'(a), {$urandom, $urandom}, bmask, 0, $sformatf("rnd_init%0d_%0d", k, p), obs);
            end
            for (int i = 0; i < 25; i++) begin
                idx  = $urandom_range(0, 8);
                if (idx == 8) idx = P_DEPTH[k] - 1;
                mode = $urandom_range(0, 9);
                if (mode == 1) idx = P_DEPTH[k] + $urandom_range(0, 5);
                a = P_BASE[k] + longint'(idx) * P_BW[k];
                if (mode == 0) a = a + $urandom_range(1, P_BW[k] - 1);
                run_txn(k, 1'($urandom_range(0, 1)), 32'(a), {$urandom, $urandom}, 8'($urandom) & bmask,
                        $urandom_range(0, 2), $sformatf("rnd%0d_%0d", k, i), obs);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'h0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 64'h0;
        req_be    = 8'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_basic();
        test_latency();
        test_errors();
        test_reset_midflight();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
